qupls_erc_sequencer: RTL and testbench

Serialization controller for instructions the decoder flags as ERC. It sits between decode and dispatch. When an ERC instruction is accepted, it stalls all younger decode and waits until every older instruction has committed. It then grants the ERC instruction a one-cycle issue permit and holds the stall until that instruction itself commits or the pipeline is flushed.

---
 rtl/qupls_erc_sequencer_pkg.sv | 19 +
 rtl/qupls_erc_sequencer_watchdog.sv | 35 +++
 rtl/qupls_erc_sequencer.sv | 121 ++++++++++++
 tb/tb_qupls_erc_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qupls_erc_sequencer_pkg.sv
// Shared types for the ERC serialization sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: erc_state_t (sequencer FSM states) and rob_ndx_t (ROB tag type).
package QuplsPkg;

    localparam int ROB_ENTRIES = 16;
    localparam int TW          = $clog2(ROB_ENTRIES);

    typedef logic [TW-1:0] rob_ndx_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DRAIN    = 2'd1,
        ISSUE    = 2'd2,
        WAIT_CMT = 2'd3
    } erc_state_t;

endpackage

// File: rtl/qupls_erc_sequencer_watchdog.sv
// Cycle counter that flags a stuck ERC sequence after LIMIT counted cycles.
// Latency: o_expired is combinational from the count, asserted on the LIMIT-th counted cycle.
// Backpressure: none; the caller owns clear/enable.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   i_count_en  - count this cycle (sequencer is waiting)
//   i_clear     - synchronous clear, wins over i_count_en
//   o_expired   - count has reached LIMIT-1 while counting
module qupls_erc_watchdog #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_count_en,
    input  logic i_clear,
    output logic o_expired
);

    localparam int CW = (LIMIT > 2) ? $clog2(LIMIT) : 1;

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_count_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = i_count_en & (r_cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/qupls_erc_sequencer.sv
// Serializes ERC instructions: stalls younger decode, drains older work, issues the ERC alone.
// Latency: accept edge N -> DRAIN N+1 -> ISSUE >= N+2 -> WAIT_CMT -> IDLE the cycle after its commit.
// Backpressure: dec_stall is a pure decode of the state register (no input-to-output path).
// Optional feature: define QUPLS_ERC_WATCHDOG_EN to compile in the TIMEOUT_CYC watchdog.
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   dec_v, dec_erc, dec_tag    - decode slot valid, ERC flag, ROB tag
//   dec_stall                  - hold off further decode/dispatch
//   rob_head_v, rob_head_tag   - oldest uncommitted ROB entry
//   cmt_v, cmt_tag             - commit pulse and tag
//   flush                      - pipeline flush, aborts the sequence
//   erc_issue, erc_tag         - one-cycle issue permit, captured ERC tag
//   erc_active, erc_timeout    - sequencer busy, watchdog expiry pulse
module qupls_erc_sequencer
    import QuplsPkg::*;
#(
    parameter int ROB_ENTRIES = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           dec_v,
    input  logic                           dec_erc,
    input  logic [$clog2(ROB_ENTRIES)-1:0] dec_tag,
    output logic                           dec_stall,
    input  logic [$clog2(ROB_ENTRIES)-1:0] rob_head_tag,
    input  logic                           rob_head_v,
    input  logic                           cmt_v,
    input  logic [$clog2(ROB_ENTRIES)-1:0] cmt_tag,
    input  logic                           flush,
    output logic                           erc_issue,
    output logic [$clog2(ROB_ENTRIES)-1:0] erc_tag,
    output logic                           erc_active,
    output logic                           erc_timeout
);

    localparam int TAGW = $clog2(ROB_ENTRIES);

    erc_state_t      r_state;
    erc_state_t      w_next;
    logic [TAGW-1:0] r_erc_tag;

    logic w_accept;
    logic w_head_match;
    logic w_cmt_match;
    logic w_timeout;

    assign w_accept     = dec_v & dec_erc & ~flush;
    // Tags wrap mod ROB_ENTRIES, so only exact equality is meaningful.
    assign w_head_match = rob_head_v & (rob_head_tag == r_erc_tag);
    assign w_cmt_match  = cmt_v & (cmt_tag == r_erc_tag);

`ifdef QUPLS_ERC_WATCHDOG_EN
    logic w_wd_count;
    logic w_wd_clear;
    logic w_wd_expired;

    assign w_wd_count = ((r_state == DRAIN) || (r_state == WAIT_CMT)) & ~flush;
    assign w_wd_clear = flush | w_timeout | (r_state == IDLE) | (r_state == ISSUE);

    qupls_erc_watchdog #(
        .LIMIT (TIMEOUT_CYC)
    ) u_watchdog (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_count_en (w_wd_count),
        .i_clear    (w_wd_clear),
        .o_expired  (w_wd_expired)
    );

    // A commit that completes the sequence on the expiry cycle is real progress,
    // so it suppresses the timeout rather than reporting a false hang.
    assign w_timeout = w_wd_expired & ~flush & ~((r_state == WAIT_CMT) & w_cmt_match);
`else
    logic w_unused_cfg;
    assign w_unused_cfg = &{1'b0, TIMEOUT_CYC[0]};
    assign w_timeout    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     if (w_accept)     w_next = DRAIN;
            DRAIN:    if (w_head_match) w_next = ISSUE;
            ISSUE:                      w_next = WAIT_CMT;
            WAIT_CMT: if (w_cmt_match)  w_next = IDLE;
            default:                    w_next = IDLE;
        endcase
        if (w_timeout) begin
            w_next = IDLE;
        end
        // Flush overrides everything, including a same-cycle drain or commit match.
        if (flush) begin
            w_next = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_erc_tag <= '0;
        end else if ((r_state == IDLE) && w_accept) begin
            r_erc_tag <= dec_tag;
        end
    end

    assign dec_stall   = (r_state != IDLE);
    assign erc_active  = dec_stall;
    // Not masked by flush: the consumer qualifies the permit with ~flush.
    assign erc_issue   = (r_state == ISSUE);
    assign erc_tag     = r_erc_tag;
    assign erc_timeout = w_timeout;

endmodule

// File: tb/tb_qupls_erc_sequencer.sv
module tb_qupls_erc_sequencer;

    logic       clk;
    logic       rst_n;
    logic       dec_v;
    logic       dec_erc;
    logic [3:0] dec_tag;
    logic       dec_stall;
    logic [3:0] rob_head_tag;
    logic       rob_head_v;
    logic       cmt_v;
    logic [3:0] cmt_tag;
    logic       flush;
    logic       erc_issue;
    logic [3:0] erc_tag;
    logic       erc_active;
    logic       erc_timeout;

    int errors = 0;
    int checks = 0;

    qupls_erc_sequencer #(
        .ROB_ENTRIES (16),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dec_v        (dec_v),
        .dec_erc      (dec_erc),
        .dec_tag      (dec_tag),
        .dec_stall    (dec_stall),
        .rob_head_tag (rob_head_tag),
        .rob_head_v   (rob_head_v),
        .cmt_v        (cmt_v),
        .cmt_tag      (cmt_tag),
        .flush        (flush),
        .erc_issue    (erc_issue),
        .erc_tag      (erc_tag),
        .erc_active   (erc_active),
        .erc_timeout  (erc_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs are driven there.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        dec_v = 0; dec_erc = 0; dec_tag = 0;
        rob_head_v = 1; rob_head_tag = 4'd2;
        cmt_v = 0; cmt_tag = 0; flush = 0;
    endtask

    // Drive an ERC into decode for one cycle, leaving the edge taken.
    task automatic accept(input logic [3:0] tag);
        dec_v = 1; dec_erc = 1; dec_tag = tag;
        step();
        dec_v = 0; dec_erc = 0; dec_tag = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle_inputs();
        repeat (2) step();
        #2;
        checks++;
        if ({dec_stall, erc_issue, erc_active, erc_timeout, erc_tag} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs got=%b want=00000000",
                     {dec_stall, erc_issue, erc_active, erc_timeout, erc_tag});
        end
        rst_n = 1;
        step();
        // Non-ERC instruction in IDLE must not start a sequence.
        dec_v = 1; dec_erc = 0; dec_tag = 4'd6;
        step();
        dec_v = 0;
        #2;
        checks++;
        if (dec_stall !== 1'b0) begin
            errors++;
            $display("FAIL non_erc_ignored stall got=%b want=0", dec_stall);
        end
    endtask

    task automatic test_basic();
        // cycle 0: ERC tag 5 in decode, head at 2; ERC itself is not stalled.
        dec_v = 1; dec_erc = 1; dec_tag = 4'd5;
        rob_head_v = 1; rob_head_tag = 4'd2;
        #2;
        checks++;
        if (dec_stall !== 1'b0) begin
            errors++;
            $display("FAIL basic_c0_stall got=%b want=0", dec_stall);
        end
        step();
        for (int c = 1; c <= 10; c++) begin
            dec_v = 0; dec_erc = 0; dec_tag = 0; cmt_v = 0; cmt_tag = 0;
            if (c == 3) begin
                // Younger ERC while busy is ignored; wrong-tag commit has no effect.
                dec_v = 1; dec_erc = 1; dec_tag = 4'd9;
                cmt_v = 1; cmt_tag = 4'd2;
            end
            if (c >= 7) rob_head_tag = 4'd5;
            if (c == 10) begin cmt_v = 1; cmt_tag = 4'd5; end
            #2;
            checks++;
            if (dec_stall !== 1'b1 || erc_active !== 1'b1) begin
                errors++;
                $display("FAIL basic_stall c%0d got=%b/%b want=1/1", c, dec_stall, erc_active);
            end
            checks++;
            if (erc_issue !== (c == 8)) begin
                errors++;
                $display("FAIL basic_issue c%0d got=%b want=%b", c, erc_issue, (c == 8));
            end
            checks++;
            if (erc_tag !== 4'd5) begin
                errors++;
                $display("FAIL basic_tag c%0d got=%0d want=5", c, erc_tag);
            end
            step();
        end
        cmt_v = 0; cmt_tag = 0;
        #2;
        checks++;
        if (dec_stall !== 1'b0 || erc_active !== 1'b0 || erc_issue !== 1'b0) begin
            errors++;
            $display("FAIL basic_c11_idle got=%b%b%b want=000", dec_stall, erc_active, erc_issue);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_immediate_drain();
        rob_head_tag = 4'd3;
        accept(4'd3);
        #2;
        checks++;
        if (erc_issue !== 1'b0 || dec_stall !== 1'b1) begin
            errors++;
            $display("FAIL imm_c1 issue/stall got=%b/%b want=0/1", erc_issue, dec_stall);
        end
        step();
        #2;
        checks++;
        if (erc_issue !== 1'b1 || erc_tag !== 4'd3) begin
            errors++;
            $display("FAIL imm_c2 issue/tag got=%b/%0d want=1/3", erc_issue, erc_tag);
        end
        step();
        // WAIT_CMT: commit of a different tag must not release.
        cmt_v = 1; cmt_tag = 4'd11;
        step();
        #2;
        checks++;
        if (dec_stall !== 1'b1) begin
            errors++;
            $display("FAIL imm_wrong_cmt stall got=%b want=1", dec_stall);
        end
        cmt_tag = 4'd3;
        step();
        cmt_v = 0;
        #2;
        checks++;
        if (dec_stall !== 1'b0) begin
            errors++;
            $display("FAIL imm_release stall got=%b want=0", dec_stall);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_flush_drain();
        rob_head_tag = 4'd2;
        accept(4'd7);
        for (int c = 1; c <= 4; c++) begin
            flush = (c == 3);
            // Drain match arrives together with the flush; flush must win.
            if (c == 3) rob_head_tag = 4'd7;
            if (c == 4) rob_head_tag = 4'd2;
            #2;
            checks++;
            if (erc_issue !== 1'b0 || dec_stall !== (c != 4)) begin
                errors++;
                $display("FAIL flush_drain c%0d issue/stall got=%b/%b want=0/%b",
                         c, erc_issue, dec_stall, (c != 4));
            end
            step();
        end
        idle_inputs();
        step();
    endtask

    task automatic test_flush_issue_and_commit();
        // Flush during ISSUE: permit still visible that cycle, IDLE next.
        rob_head_tag = 4'd4;
        accept(4'd4);
        step();
        flush = 1;
        #2;
        checks++;
        if (erc_issue !== 1'b1) begin
            errors++;
            $display("FAIL flush_issue permit got=%b want=1", erc_issue);
        end
        step();
        flush = 0;
        #2;
        checks++;
        if (dec_stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_issue_idle stall got=%b want=0", dec_stall);
        end
        // Flush together with a matching commit in WAIT_CMT.
        rob_head_tag = 4'd12;
        accept(4'd12);
        step();
        step();
        flush = 1; cmt_v = 1; cmt_tag = 4'd12;
        #2;
        checks++;
        if (erc_timeout !== 1'b0 || dec_stall !== 1'b1) begin
            errors++;
            $display("FAIL flush_cmt_same timeout/stall got=%b/%b want=0/1", erc_timeout, dec_stall);
        end
        step();
        flush = 0; cmt_v = 0;
        #2;
        checks++;
        if (dec_stall !== 1'b0 || erc_timeout !== 1'b0) begin
            errors++;
            $display("FAIL flush_cmt_next stall/timeout got=%b/%b want=0/0", dec_stall, erc_timeout);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_reset_midop();
        rob_head_tag = 4'd10;
        accept(4'd10);
        step();
        step();
        #2;
        rst_n = 0;
        #1;
        checks++;
        if ({dec_stall, erc_issue, erc_active, erc_timeout, erc_tag} !== 8'h00) begin
            errors++;
            $display("FAIL async_reset got=%b want=00000000",
                     {dec_stall, erc_issue, erc_active, erc_timeout, erc_tag});
        end
        step();
        rst_n = 1;
        step();
        rob_head_tag = 4'd9;
        accept(4'd9);
        step();
        #2;
        checks++;
        if (erc_issue !== 1'b1 || erc_tag !== 4'd9) begin
            errors++;
            $display("FAIL after_reset issue/tag got=%b/%0d want=1/9", erc_issue, erc_tag);
        end
        step();
        cmt_v = 1; cmt_tag = 4'd9;
        step();
        idle_inputs();
        step();
    endtask

    task automatic test_watchdog();
        int pulses;
        pulses = 0;
        rob_head_tag = 4'd1;
        accept(4'd14);
`ifdef QUPLS_ERC_WATCHDOG_EN
        // DRAIN cycles 1..8; expiry on the 8th, IDLE on the 9th.
        for (int c = 1; c <= 9; c++) begin
            #2;
            if (erc_timeout === 1'b1) pulses++;
            checks++;
            if (erc_timeout !== (c == 8)) begin
                errors++;
                $display("FAIL wd_pulse c%0d got=%b want=%b", c, erc_timeout, (c == 8));
            end
            checks++;
            if (dec_stall !== (c != 9)) begin
                errors++;
                $display("FAIL wd_state c%0d stall got=%b want=%b", c, dec_stall, (c != 9));
            end
            step();
        end
        for (int c = 10; c <= 20; c++) begin
            if (erc_timeout === 1'b1) pulses++;
            step();
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL wd_pulse_count got=%0d want=1", pulses);
        end
`else
        for (int c = 1; c <= 20; c++) begin
            #2;
            if (erc_timeout !== 1'b0) pulses++;
            step();
        end
        checks++;
        if (pulses != 0 || dec_stall !== 1'b1) begin
            errors++;
            $display("FAIL wd_disabled pulses/stall got=%0d/%b want=0/1", pulses, dec_stall);
        end
        flush = 1;
        step();
        flush = 0;
`endif
        idle_inputs();
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_immediate_drain();
        test_flush_drain();
        test_flush_issue_and_commit();
        test_reset_midop();
        test_watchdog();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
